alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 35 +++
 rtl/mod_alu.sv | 62 ++++++
 rtl/alu_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : ALU op codes, op-code width and arbiter FSM state type.
//  Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam int OP_WIDTH = 4;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_NOT = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SLA = 4'd6,
        OP_SLL = 4'd7,
        OP_SRA = 4'd8,
        OP_SRL = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [OP_WIDTH-1:0] op);
        return (op <= OP_SRL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_alu.sv
`default_nettype none
// ============================================================================
//  Module   : mod_alu
//  Brief    : Combinational WIDTH-bit ALU; subtraction returns magnitude + sign.
//  Revision : 1.0
// ============================================================================
module mod_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [OP_WIDTH-1:0] op,
    output logic [WIDTH-1:0]    result,
    output logic                cout,
    output logic                negative,
    output logic                zero
);

    alu_op_t w_op;
    assign w_op = alu_op_t'(op);

    always_comb begin
        result   = '0;
        cout     = 1'b0;
        negative = 1'b0;
        case (w_op)
            OP_ADD: {cout, result} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                if (a >= b) begin
                    result = a - b;
                end else begin
                    result   = b - a;
                    negative = 1'b1;
                end
            end
            OP_NOT: result = ~a;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            // Arithmetic left shift keeps the sign bit; cout is the magnitude bit lost.
            OP_SLA: begin
                result = {a[WIDTH-1], a[WIDTH-2:0] << 1};
                cout   = a[WIDTH-2];
            end
            OP_SLL: {cout, result} = {a, 1'b0};
            OP_SRA: begin
                result = {a[WIDTH-1], a[WIDTH-1:1]};
                cout   = a[0];
            end
            OP_SRL: begin
                result = {1'b0, a[WIDTH-1:1]};
                cout   = a[0];
            end
            default: ;
        endcase
        zero = (result == '0);
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Brief    : Two requesters share one ALU via an IDLE/EXEC/RESP handshake FSM.
//             ALU_ARB_RR_EN selects round-robin grant (default: req0 priority).
//  Revision : 1.0
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [WIDTH-1:0]    req0_a,
    input  logic [WIDTH-1:0]    req0_b,
    input  logic [OP_WIDTH-1:0] req0_op,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [WIDTH-1:0]    req1_a,
    input  logic [WIDTH-1:0]    req1_b,
    input  logic [OP_WIDTH-1:0] req1_op,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_id,
    output logic [WIDTH-1:0]    resp_result,
    output logic                resp_cout,
    output logic                resp_negative,
    output logic                resp_zero,
    output logic                resp_err,
    output logic                busy
);

    state_t                r_state;
    state_t                w_next;
    logic [WIDTH-1:0]      r_a;
    logic [WIDTH-1:0]      r_b;
    logic [OP_WIDTH-1:0]   r_op;
    logic                  r_id;
    logic                  w_idle;
    logic                  w_grant1;
    logic                  w_accept;
    logic [WIDTH-1:0]      w_alu_result;
    logic                  w_alu_cout;
    logic                  w_alu_negative;
    logic                  w_alu_zero;
    logic                  w_legal;

`ifdef ALU_ARB_RR_EN
    // r_ptr names the requester preferred on a tie; it flips away from each winner.
    logic r_ptr;
    assign w_grant1 = req1_valid & (~req0_valid | r_ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= ~w_grant1;
        end
    end
`else
    assign w_grant1 = req1_valid & ~req0_valid;
`endif

    assign w_idle     = (r_state == ST_IDLE) & ~rst;
    assign req0_ready = w_idle & req0_valid & ~w_grant1;
    assign req1_ready = w_idle & w_grant1;
    assign w_accept   = req0_ready | req1_ready;
    assign resp_valid = (r_state == ST_RESP) & ~rst;
    assign busy       = (r_state != ST_IDLE) & ~rst;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)   w_next = ST_EXEC;
            ST_EXEC:                 w_next = ST_RESP;
            ST_RESP: if (resp_ready) w_next = ST_IDLE;
            default:                 w_next = ST_IDLE;
        endcase
    end

    mod_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .a        (r_a),
        .b        (r_b),
        .op       (r_op),
        .result   (w_alu_result),
        .cout     (w_alu_cout),
        .negative (w_alu_negative),
        .zero     (w_alu_zero)
    );

    assign w_legal = op_is_legal(r_op);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_id          <= 1'b0;
            resp_id       <= 1'b0;
            resp_result   <= '0;
            resp_cout     <= 1'b0;
            resp_negative <= 1'b0;
            resp_zero     <= 1'b0;
            resp_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a  <= w_grant1 ? req1_a  : req0_a;
                r_b  <= w_grant1 ? req1_b  : req0_b;
                r_op <= w_grant1 ? req1_op : req0_op;
                r_id <= w_grant1;
            end
            // Illegal op codes bypass the ALU and report a cleared result.
            if (r_state == ST_EXEC) begin
                resp_id       <= r_id;
                resp_result   <= w_legal ? w_alu_result : '0;
                resp_cout     <= w_legal & w_alu_cout;
                resp_negative <= w_legal & w_alu_negative;
                resp_zero     <= w_legal & w_alu_zero;
                resp_err      <= ~w_legal;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Brief    : Directed self-checking bench for alu_arbiter (both grant builds).
//  Revision : 1.0
// ============================================================================
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a, req0_b, req0_op;
    logic [3:0] req1_a, req1_b, req1_op;
    logic       resp_valid, resp_ready, resp_id;
    logic [3:0] resp_result;
    logic       resp_cout, resp_negative, resp_zero, resp_err, busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_cout(resp_cout),
        .resp_negative(resp_negative), .resp_zero(resp_zero),
        .resp_err(resp_err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic id, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] op, input logic [3:0] er, input logic ec,
                           input logic en, input logic ez, input logic ee);
        int n;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1;
        n = 0;
        while (!(req0_ready | req1_ready) && n < 8) begin
            tick();
            n++;
        end
        chk("accept_ready", 8'(id ? req1_ready : req0_ready), 8'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("exec_busy", 8'(busy), 8'd1);
        chk("exec_resp_valid", 8'(resp_valid), 8'd0);
        tick();
        chk("resp_valid", 8'(resp_valid), 8'd1);
        chk("resp_id", 8'(resp_id), 8'(id));
        chk("resp_result", 8'(resp_result), 8'(er));
        chk("resp_cout", 8'(resp_cout), 8'(ec));
        chk("resp_negative", 8'(resp_negative), 8'(en));
        chk("resp_zero", 8'(resp_zero), 8'(ez));
        chk("resp_err", 8'(resp_err), 8'(ee));
        chk("resp_readys", 8'({req0_ready, req1_ready}), 8'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("idle_busy", 8'(busy), 8'd0);
        chk("idle_resp_valid", 8'(resp_valid), 8'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        #1;
        chk("rst_ready0", 8'(req0_ready), 8'd0);
        tick();
        tick();
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_resp_valid", 8'(resp_valid), 8'd0);
        chk("rst_resp_bits", 8'({resp_result, resp_cout, resp_negative, resp_zero, resp_err}), 8'd0);
        req0_valid = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_g;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        do_reset();
        tick();

        run_job(1'b0, 4'b1110, 4'b0101, 4'd0, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
        run_job(1'b1, 4'b0110, 4'b1010, 4'd1, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
        run_job(1'b1, 4'b1010, 4'b0011, 4'd1, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(1'b0, 4'b0101, 4'b0101, 4'd5, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        run_job(1'b0, 4'b1010, 4'b0000, 4'd8, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(1'b0, 4'b1111, 4'b0001, 4'd12, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        run_job(1'b0, 4'b1110, 4'b0000, 4'd9, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);

        // Response stall: outputs frozen, no new grant while requester 1 waits.
        req0_valid = 1'b1; req0_a = 4'b1100; req0_b = 4'b1010; req0_op = 4'd3;
        tick();
        req0_valid = 1'b0;
        tick();
        req1_valid = 1'b1; req1_a = 4'b0001; req1_b = 4'b0001; req1_op = 4'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_resp_valid", 8'(resp_valid), 8'd1);
            chk("stall_result", 8'(resp_result), 8'b0000_1000);
            chk("stall_readys", 8'({req0_ready, req1_ready}), 8'd0);
            chk("stall_busy", 8'(busy), 8'd1);
            tick();
        end
        // Requester 1 withdraws before being granted: nothing may be captured.
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("idle_no_capture", 8'({busy, resp_valid}), 8'd0);
            tick();
        end
        resp_ready = 1'b0;

        // Contention: fresh reset puts the round-robin pointer back on req0.
        do_reset();
        tick();
        req0_valid = 1'b1; req0_a = 4'b0001; req0_b = 4'b0001; req0_op = 4'd0;
        req1_valid = 1'b1; req1_a = 4'b0100; req1_b = 4'b1000; req1_op = 4'd4;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
            exp_g = (i % 2 == 1);
`else
            exp_g = 1'b0;
`endif
            #1;
            chk("grant_readys", 8'({req0_ready, req1_ready}), exp_g ? 8'b01 : 8'b10);
            tick();
            tick();
            chk("grant_resp_id", 8'(resp_id), 8'(exp_g));
            chk("grant_result", 8'(resp_result), exp_g ? 8'b0000_1100 : 8'b0000_0010);
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Reset while executing discards the job.
        req0_valid = 1'b1; req0_a = 4'b0011; req0_b = 4'b0011; req0_op = 4'd0;
        tick();
        req0_valid = 1'b0;
        chk("abort_exec_busy", 8'(busy), 8'd1);
        rst = 1'b1;
        tick();
        chk("abort_busy", 8'(busy), 8'd0);
        chk("abort_resp_valid", 8'(resp_valid), 8'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_resp", 8'({busy, resp_valid}), 8'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
